// File: rtl/isa_shared.sv
// Shared ISA-level types for the execute/memory stages: memory op encoding, LSU states, lane helpers.
`timescale 1ns/1ps
package isa_shared;

    localparam int XLEN       = 32;
    localparam int BYTE_LANES = XLEN / 8;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_ops_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    function automatic logic is_load(input mem_ops_e op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input mem_ops_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input mem_ops_e op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: bad = off[0];
            MEM_LW, MEM_SW:          bad = (off != 2'b00);
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a raw memory word.
// Latency: combinational. Backpressure: none (pure function of its inputs).
`timescale 1ns/1ps
module load_align
    import isa_shared::*;
(
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      off,
    input  mem_ops_e        mem_op,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data  = '0;
        case (mem_op)
            MEM_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: ld_data = {24'b0, byte_sel};
            MEM_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: ld_data = {16'b0, half_sel};
            MEM_LW:  ld_data = mem_rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding req/gnt/rvalid bus master with valid/ready writeback.
// Latency: pass-through/fault 1 cycle; load >= 3 cycles (gnt and rvalid dependent).
// Backpressure: in_ready only in IDLE; RESP holds all outputs until out_ready.
`timescale 1ns/1ps
module lsu
    import isa_shared::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_WIDTH-1:0]     alu_result,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  mem_ops_e                  mem_op,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_we,
    output logic                      out_misaligned,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [BYTE_LANES-1:0]     mem_wstrb,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    lsu_state_e            state;
    mem_ops_e              op_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [BYTE_LANES-1:0] st_wstrb;
    logic [DATA_WIDTH-1:0] ld_data;

    assign in_ready = (state == ST_IDLE);

    // Store lanes are computed from the live inputs so they can be registered at accept.
    always_comb begin
        st_wdata = '0;
        st_wstrb = '0;
        case (mem_op)
            MEM_SB: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << alu_result[1:0];
            end
            MEM_SH: begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = 4'b0011 << alu_result[1:0];
            end
            MEM_SW: begin
                st_wdata = store_data;
                st_wstrb = 4'b1111;
            end
            default: begin
                st_wdata = '0;
                st_wstrb = '0;
            end
        endcase
    end

    load_align u_load_align (
        .mem_rdata (mem_rdata),
        .off       (off_q),
        .mem_op    (op_q),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            op_q           <= MEM_NONE;
            off_q          <= 2'b00;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wstrb      <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_rd         <= '0;
            out_we         <= 1'b0;
            out_misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q           <= mem_op;
                        off_q          <= alu_result[1:0];
                        out_rd         <= rd_in;
                        out_data       <= '0;
                        out_we         <= 1'b0;
                        out_misaligned <= 1'b0;
                        if (mem_op == MEM_NONE) begin
                            out_data  <= alu_result[DATA_WIDTH-1:0];
                            out_we    <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else if (is_misaligned(mem_op, alu_result[1:0])) begin
                            out_misaligned <= 1'b1;
                            out_valid      <= 1'b1;
                            state          <= ST_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store(mem_op);
                            mem_addr  <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata <= st_wdata;
                            mem_wstrb <= st_wstrb;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        if (is_load(op_q)) begin
                            state <= ST_WAIT;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        out_data  <= ld_data;
                        out_we    <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: pass-through, loads, stores, faults, backpressure, mid-transaction reset.
`timescale 1ns/1ps
module tb_lsu;
    import isa_shared::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    mem_ops_e    mem_op;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .mem_op         (mem_op),
        .rd_in          (rd_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_rd         (out_rd),
        .out_we         (out_we),
        .out_misaligned (out_misaligned),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Waits (bounded) for in_ready, offers one op for one edge, then scrambles the inputs.
    task automatic offer(input string tag, input mem_ops_e op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd);
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        mem_op     = op;
        alu_result = addr;
        store_data = sd;
        rd_in      = rd;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        mem_op     = MEM_SW;
        alu_result = 32'hFFFF_FFFF;
        store_data = 32'h5A5A_5A5A;
        rd_in      = 5'h1F;
    endtask

    // Load with immediate grant and rvalid the cycle after; ends in the first RESP cycle.
    task automatic do_load(input string tag, input mem_ops_e op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp);
        mem_gnt = 1'b1;
        offer(tag, op, addr, 32'h0, rd);
        chk1 ({tag, "_req"},   mem_req, 1'b1);
        chk32({tag, "_addr"},  mem_addr, addr & 32'hFFFF_FFFC);
        chk1 ({tag, "_we"},    mem_we, 1'b0);
        chk32({tag, "_wstrb"}, {28'b0, mem_wstrb}, 32'h0);
        @(negedge clk);
        mem_gnt    = 1'b0;
        chk1({tag, "_req_drop"}, mem_req, 1'b0);
        chk1({tag, "_no_early_valid"}, out_valid, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk1 ({tag, "_out_valid"}, out_valid, 1'b1);
        chk32({tag, "_out_data"},  out_data, exp);
        chk1 ({tag, "_out_we"},    out_we, 1'b1);
        chk32({tag, "_out_rd"},    {27'b0, out_rd}, {27'b0, rd});
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        alu_result = 32'h0;
        store_data = 32'h0;
        mem_op     = MEM_NONE;
        rd_in      = 5'h0;
        out_ready  = 1'b1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk1 ("rst_in_ready",   in_ready, 1'b1);
        chk1 ("rst_out_valid",  out_valid, 1'b0);
        chk1 ("rst_mem_req",    mem_req, 1'b0);
        chk32("rst_out_data",   out_data, 32'h0);
        chk1 ("rst_out_we",     out_we, 1'b0);
        chk1 ("rst_misaligned", out_misaligned, 1'b0);
        chk32("rst_wstrb",      {28'b0, mem_wstrb}, 32'h0);

        // Pass-through
        offer("none", MEM_NONE, 32'h1234_5678, 32'h0, 5'd5);
        chk1 ("none_out_valid", out_valid, 1'b1);
        chk32("none_out_data",  out_data, 32'h1234_5678);
        chk32("none_out_rd",    {27'b0, out_rd}, 32'd5);
        chk1 ("none_out_we",    out_we, 1'b1);
        chk1 ("none_no_req",    mem_req, 1'b0);
        chk1 ("none_busy",      in_ready, 1'b0);
        @(negedge clk);
        chk1 ("none_valid_drop", out_valid, 1'b0);
        chk1 ("none_ready_back", in_ready, 1'b1);

        // Loads
        do_load("lb",  MEM_LB,  32'h0000_1003, 32'h80FF_0011, 5'd10, 32'hFFFF_FF80);
        do_load("lbu", MEM_LBU, 32'h0000_1003, 32'h80FF_0011, 5'd11, 32'h0000_0080);
        do_load("lh",  MEM_LH,  32'h0000_1002, 32'h80FF_0011, 5'd12, 32'hFFFF_80FF);
        do_load("lhu", MEM_LHU, 32'h0000_1000, 32'h80FF_8011, 5'd13, 32'h0000_8011);
        do_load("lw",  MEM_LW,  32'h0000_1004, 32'h80FF_0011, 5'd14, 32'h80FF_0011);

        // Store half with grant delayed three cycles
        mem_gnt = 1'b0;
        offer("sh", MEM_SH, 32'h0000_2002, 32'hAAAA_BEEF, 5'd3);
        for (int k = 0; k < 4; k++) begin
            chk1 ("sh_req",   mem_req, 1'b1);
            chk32("sh_addr",  mem_addr, 32'h0000_2000);
            chk32("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
            chk32("sh_wstrb", {28'b0, mem_wstrb}, 32'hC);
            chk1 ("sh_we",    mem_we, 1'b1);
            chk1 ("sh_busy",  in_ready, 1'b0);
            if (k == 3) mem_gnt = 1'b1;
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        chk1 ("sh_req_drop",  mem_req, 1'b0);
        chk1 ("sh_out_valid", out_valid, 1'b1);
        chk1 ("sh_out_we",    out_we, 1'b0);
        chk32("sh_out_data",  out_data, 32'h0);
        chk1 ("sh_misaligned", out_misaligned, 1'b0);

        // Store byte at offset 1, immediate grant
        mem_gnt = 1'b1;
        offer("sb", MEM_SB, 32'h0000_2001, 32'h1234_56A5, 5'd4);
        chk32("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk32("sb_wstrb", {28'b0, mem_wstrb}, 32'h2);
        chk1 ("sb_we",    mem_we, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b0;
        chk1 ("sb_out_valid", out_valid, 1'b1);
        chk1 ("sb_out_we",    out_we, 1'b0);

        // Misaligned faults
        offer("lw_mis", MEM_LW, 32'h0000_3001, 32'h0, 5'd6);
        chk1 ("lw_mis_flag",  out_misaligned, 1'b1);
        chk1 ("lw_mis_valid", out_valid, 1'b1);
        chk1 ("lw_mis_we",    out_we, 1'b0);
        chk32("lw_mis_data",  out_data, 32'h0);
        chk1 ("lw_mis_req",   mem_req, 1'b0);
        @(negedge clk);
        chk1 ("lw_mis_req2",  mem_req, 1'b0);
        offer("sh_mis", MEM_SH, 32'h0000_3001, 32'h0000_FFFF, 5'd6);
        chk1 ("sh_mis_flag",  out_misaligned, 1'b1);
        chk1 ("sh_mis_valid", out_valid, 1'b1);
        chk1 ("sh_mis_we",    out_we, 1'b0);
        chk32("sh_mis_data",  out_data, 32'h0);
        chk1 ("sh_mis_req",   mem_req, 1'b0);
        @(negedge clk);
        chk1 ("sh_mis_req2",  mem_req, 1'b0);

        // Backpressure: result held for five cycles, offered op refused
        out_ready = 1'b0;
        do_load("bp", MEM_LW, 32'h0000_4000, 32'hDEAD_BEEF, 5'd9, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            chk1 ("bp_hold_valid", out_valid, 1'b1);
            chk32("bp_hold_data",  out_data, 32'hDEAD_BEEF);
            chk32("bp_hold_rd",    {27'b0, out_rd}, 32'd9);
            chk1 ("bp_in_ready",   in_ready, 1'b0);
            if (k == 1) begin
                mem_op     = MEM_NONE;
                alu_result = 32'h0000_0055;
                rd_in      = 5'd1;
                in_valid   = 1'b1;
            end
            if (k == 2) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk1("bp_still_valid", out_valid, 1'b1);
        @(negedge clk);
        chk1 ("bp_valid_drop", out_valid, 1'b0);
        chk1 ("bp_ready_back", in_ready, 1'b1);
        chk32("bp_not_taken",  out_data, 32'hDEAD_BEEF);

        // Reset while waiting for load data
        mem_gnt = 1'b1;
        offer("rw", MEM_LB, 32'h0000_5000, 32'h0, 5'd12);
        @(negedge clk);
        mem_gnt = 1'b0;
        chk1("rw_in_wait", mem_req, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk1 ("rw_mem_req",   mem_req, 1'b0);
        chk1 ("rw_out_valid", out_valid, 1'b0);
        chk32("rw_out_rd",    {27'b0, out_rd}, 32'h0);
        chk32("rw_mem_addr",  mem_addr, 32'h0);
        chk1 ("rw_in_ready",  in_ready, 1'b1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_00FF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk1 ("rw_stray_1", out_valid, 1'b0);
        @(negedge clk);
        chk1 ("rw_stray_2", out_valid, 1'b0);
        offer("rw_none", MEM_NONE, 32'hCAFE_F00D, 32'h0, 5'd7);
        chk1 ("rw_none_valid", out_valid, 1'b1);
        chk32("rw_none_data",  out_data, 32'hCAFE_F00D);
        chk32("rw_none_rd",    {27'b0, out_rd}, 32'd7);
        chk1 ("rw_none_we",    out_we, 1'b1);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
